// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl: Q*bert move sequencer; turns direction commands into sprite-layer jumps
// and tracks position, visited cubes, score, lives and level/game state.
module qbert_jump_ctrl #(
    parameter int N_ROWS   = 7,
    parameter int N_CUBE   = N_ROWS * (N_ROWS + 1) / 2,
    parameter int PTS_CUBE = 25,
    parameter int N_LIVES  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_restart,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_dir,
    output logic              cmd_ready,
    input  logic              done_move,
    input  logic [2:0]        state_qb,
    output logic [2:0]        e_jump_qb,
    output logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] e_next_qb,
    output logic              e_bad_jump,
    output logic [N_CUBE-1:0] visited,
    output logic [15:0]       score,
    output logic [1:0]        lives,
    output logic              level_clear,
    output logic              game_over
);
    localparam int RW = $clog2(N_ROWS) + 1;
    localparam int IW = $clog2(N_CUBE);
    localparam int NB = 2 ** (RW - 1);
    localparam logic [2:0] IDLE = 3'b010;
    localparam logic signed [RW-1:0] MAX_ROW = RW'(N_ROWS - 1);
    localparam logic [N_CUBE-1:0] CUBE0 = N_CUBE'(1);

    typedef enum logic [2:0] {READY, LAUNCH, FLIGHT, COMMIT, SETTLE, RESPAWN} state_t;

    state_t state_q, state_d;
    logic signed [RW-1:0] row_q, row_d, col_q, col_d, tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d, tr, tc;
    logic [2:0] jump_q, jump_d;
    logic [N_CUBE-1:0] pos_q, pos_d, next_q, next_d, vis_q, vis_d, tgt_hot;
    logic bad_q, bad_d, clear_q, clear_d, over_q, over_d, bad, accept;
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;
    logic [1:0] lives_q, lives_d;
    logic [IW-1:0] row_base [NB];
    logic [IW-1:0] idx;

    genvar g;
    for (g = 0; g < NB; g++) begin : g_base
        assign row_base[g] = IW'(g * (g + 1) / 2);
    end

    assign cmd_ready = state_q == READY && state_qb == IDLE && !clear_q && !over_q;
    assign accept    = cmd_valid && cmd_ready && cmd_dir != 3'd0 && cmd_dir <= 3'd4;
    assign tr        = row_q + ((cmd_dir == 3'd1 || cmd_dir == 3'd2) ? RW'(1) : '1);
    assign tc        = col_q + (cmd_dir == 3'd1 ? RW'(1) : cmd_dir == 3'd4 ? '1 : '0);
    assign bad       = tr[RW-1] || tr > MAX_ROW || tc[RW-1] || tc > tr;
    assign idx       = row_base[tr[RW-2:0]] + IW'(tc[RW-2:0]);
    assign tgt_hot   = bad ? '0 : CUBE0 << idx;
    assign score_sum = {1'b0, score_q} + 17'(PTS_CUBE);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tgt_row_d = tgt_row_q;
        tgt_col_d = tgt_col_q;
        jump_d    = jump_q;
        pos_d     = pos_q;
        next_d    = next_q;
        vis_d     = vis_q;
        bad_d     = bad_q;
        score_d   = score_q;
        lives_d   = lives_q;
        clear_d   = clear_q;
        over_d    = over_q;
        case (state_q)
            READY: if (accept) begin
                jump_d    = cmd_dir;
                next_d    = tgt_hot;
                bad_d     = bad;
                tgt_row_d = tr;
                tgt_col_d = tc;
                state_d   = LAUNCH;
            end
            LAUNCH: state_d = done_move ? LAUNCH : FLIGHT;
            FLIGHT: state_d = !done_move ? FLIGHT : bad_q ? RESPAWN : COMMIT;
            COMMIT: begin
                pos_d   = next_q;
                row_d   = tgt_row_q;
                col_d   = tgt_col_q;
                vis_d   = vis_q | next_q;
                score_d = |(vis_q & next_q) ? score_q : score_sum[16] ? 16'hFFFF : score_sum[15:0];
                clear_d = clear_q | &(vis_q | next_q);
                state_d = SETTLE;
            end
            SETTLE: state_d = state_qb == IDLE ? READY : SETTLE;
            RESPAWN: if (state_qb == IDLE) begin
                lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
                over_d  = over_q | lives_q == 2'd1;
                row_d   = '0;
                col_d   = '0;
                pos_d   = CUBE0;
                next_d  = CUBE0;
                bad_d   = 1'b0;
                state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || e_restart) begin
            state_q   <= READY;
            row_q     <= '0;
            col_q     <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            jump_q    <= '0;
            pos_q     <= CUBE0;
            next_q    <= CUBE0;
            vis_q     <= CUBE0;
            bad_q     <= 1'b0;
            score_q   <= '0;
            lives_q   <= 2'(N_LIVES);
            clear_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            jump_q    <= jump_d;
            pos_q     <= pos_d;
            next_q    <= next_d;
            vis_q     <= vis_d;
            bad_q     <= bad_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            clear_q   <= clear_d;
            over_q    <= over_d;
        end
    end

    assign e_jump_qb   = jump_q;
    assign position_qb = pos_q;
    assign e_next_qb   = next_q;
    assign e_bad_jump  = bad_q;
    assign visited     = vis_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign level_clear = clear_q;
    assign game_over   = over_q;
endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// tb_qbert_jump_ctrl: drives qbert_jump_ctrl through a sprite-layer model and compares
// against a coordinate-level game model (row/col arithmetic, visited set, score, lives).
module tb_qbert_jump_ctrl;
    localparam logic [2:0] IDLE = 3'b010;
    localparam logic [2:0] BUSY = 3'b011;

    logic clk = 1'b0;
    logic reset, e_restart, cmd_valid, done_move, cmd_ready, e_bad_jump, level_clear, game_over;
    logic [2:0] cmd_dir, state_qb, e_jump_qb;
    logic [27:0] position_qb, e_next_qb, visited;
    logic [15:0] score;
    logic [1:0] lives;

    always #5 clk = ~clk;

    qbert_jump_ctrl dut (
        .clk(clk), .reset(reset), .e_restart(e_restart), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready), .done_move(done_move), .state_qb(state_qb), .e_jump_qb(e_jump_qb),
        .position_qb(position_qb), .e_next_qb(e_next_qb), .e_bad_jump(e_bad_jump), .visited(visited),
        .score(score), .lives(lives), .level_clear(level_clear), .game_over(game_over)
    );

    int tests = 0;
    int fails = 0;
    int m_row, m_col, m_score, m_lives;
    logic [27:0] m_pos, m_vis;
    logic [2:0] m_jump;
    bit m_clear, m_over;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_score = 0; m_lives = 3;
        m_pos = 28'd1; m_vis = 28'd1; m_jump = 3'd0; m_clear = 0; m_over = 0;
    endtask

    task automatic apply_restart(input bit use_reset);
        if (use_reset) reset = 1'b1; else e_restart = 1'b1;
        step();
        reset = 1'b0;
        e_restart = 1'b0;
        model_reset();
    endtask

    // One command through the layer model; done_move falls at +drop, rises at +rise,
    // and the layer returns to IDLE lag cycles later.
    task automatic do_move(input logic [2:0] dir, input int drop, input int rise, input int lag);
        int tr, tc, idx;
        bit bad, ok;
        logic [27:0] exp_next;
        ok = !m_clear && !m_over;
        tests++;
        if (cmd_ready !== ok) begin fails++; $display("FAIL cmd_ready: got %b expected %b", cmd_ready, ok); end
        cmd_valid = 1'b1;
        cmd_dir = dir;
        step();
        cmd_valid = 1'b0;
        if (!ok || dir == 3'd0 || dir > 3'd4) begin
            tests++;
            if ({position_qb, e_next_qb, e_jump_qb, e_bad_jump, visited} !== {m_pos, m_pos, m_jump, 1'b0, m_vis}) begin
                fails++;
                $display("FAIL dropped_cmd dir=%0d: got pos=%h next=%h jump=%0d bad=%b vis=%h expected pos=%h jump=%0d vis=%h",
                         dir, position_qb, e_next_qb, e_jump_qb, e_bad_jump, visited, m_pos, m_jump, m_vis);
            end
            return;
        end
        tr = m_row + ((dir == 3'd1 || dir == 3'd2) ? 1 : -1);
        tc = m_col + (dir == 3'd1 ? 1 : dir == 3'd4 ? -1 : 0);
        bad = tr < 0 || tr > 6 || tc < 0 || tc > tr;
        idx = bad ? 0 : tr * (tr + 1) / 2 + tc;
        exp_next = bad ? 28'd0 : 28'd1 << idx;
        m_jump = dir;
        tests++;
        if ({e_jump_qb, e_next_qb, e_bad_jump} !== {dir, exp_next, bad}) begin
            fails++;
            $display("FAIL launch dir=%0d: got jump=%0d next=%h bad=%b expected jump=%0d next=%h bad=%b",
                     dir, e_jump_qb, e_next_qb, e_bad_jump, dir, exp_next, bad);
        end
        state_qb = BUSY;
        for (int i = 1; i < rise; i++) begin
            if (i == drop) done_move = 1'b0;
            step();
        end
        done_move = 1'b1;
        repeat (lag) step();
        if (bad) begin
            tests++;
            if ({e_bad_jump, e_next_qb, lives, position_qb} !== {1'b1, 28'd0, m_lives[1:0], m_pos}) begin
                fails++;
                $display("FAIL bad_hold: got bad=%b next=%h lives=%0d pos=%h expected bad=1 next=0 lives=%0d pos=%h",
                         e_bad_jump, e_next_qb, lives, position_qb, m_lives, m_pos);
            end
        end
        state_qb = IDLE;
        step();
        step();
        if (bad) begin
            if (m_lives == 1) m_over = 1;
            m_lives = m_lives > 0 ? m_lives - 1 : 0;
            m_row = 0; m_col = 0; m_pos = 28'd1;
        end else begin
            m_row = tr; m_col = tc; m_pos = exp_next;
            if (!m_vis[idx]) m_score = m_score + 25 > 65535 ? 65535 : m_score + 25;
            m_vis[idx] = 1'b1;
            m_clear = &m_vis;
        end
        tests++;
        if ({position_qb, e_next_qb} !== {m_pos, m_pos}) begin
            fails++; $display("FAIL position: got pos=%h next=%h expected %h", position_qb, e_next_qb, m_pos);
        end
        tests++;
        if (visited !== m_vis) begin fails++; $display("FAIL visited: got %h expected %h", visited, m_vis); end
        tests++;
        if (score !== m_score[15:0]) begin fails++; $display("FAIL score: got %0d expected %0d", score, m_score); end
        tests++;
        if ({lives, level_clear, game_over, e_bad_jump} !== {m_lives[1:0], m_clear, m_over, 1'b0}) begin
            fails++;
            $display("FAIL status: got lives=%0d clear=%b over=%b bad=%b expected lives=%0d clear=%b over=%b bad=0",
                     lives, level_clear, game_over, e_bad_jump, m_lives, m_clear, m_over);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; e_restart = 1'b1;
        step();
        reset = 1'b0; e_restart = 1'b0;
        model_reset();
        tests++;
        if ({position_qb, e_next_qb, visited} !== {28'd1, 28'd1, 28'd1}) begin
            fails++; $display("FAIL reset_cubes: got pos=%h next=%h vis=%h expected 1 1 1", position_qb, e_next_qb, visited);
        end
        tests++;
        if ({e_jump_qb, e_bad_jump, score} !== {3'd0, 1'b0, 16'd0}) begin
            fails++; $display("FAIL reset_jump_score: got jump=%0d bad=%b score=%0d expected 0 0 0", e_jump_qb, e_bad_jump, score);
        end
        tests++;
        if ({lives, level_clear, game_over, cmd_ready} !== {2'd3, 1'b0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL reset_status: got lives=%0d clear=%b over=%b ready=%b expected 3 0 0 1",
                              lives, level_clear, game_over, cmd_ready);
        end
    endtask

    task automatic test_first_move();
        do_move(3'd1, 3, 20, 4);
        tests++;
        if ({position_qb, visited, score} !== {28'b100, 28'b101, 16'd25}) begin
            fails++; $display("FAIL first_move: got pos=%h vis=%h score=%0d expected 4 5 25", position_qb, visited, score);
        end
    endtask

    task automatic test_revisit();
        do_move(3'd2, 2, 9, 2);
        do_move(3'd3, 1, 7, 3);
        do_move(3'd2, 4, 12, 1);
        do_move(3'd3, 2, 5, 2);
        tests++;
        if ({position_qb, score} !== {28'b100, 16'd50}) begin
            fails++; $display("FAIL revisit: got pos=%h score=%0d expected 4 50", position_qb, score);
        end
    endtask

    task automatic test_bad_jump();
        apply_restart(1'b1);
        do_move(3'd4, 3, 15, 6);
        tests++;
        if ({lives, position_qb, score} !== {2'd2, 28'd1, 16'd0}) begin
            fails++; $display("FAIL bad_jump: got lives=%0d pos=%h score=%0d expected 2 1 0", lives, position_qb, score);
        end
    endtask

    task automatic test_game_over();
        do_move(3'd3, 2, 8, 3);
        do_move(3'd4, 1, 4, 1);
        tests++;
        if ({lives, game_over, cmd_ready} !== {2'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL game_over: got lives=%0d over=%b ready=%b expected 0 1 0", lives, game_over, cmd_ready);
        end
        do_move(3'd1, 2, 6, 2);
        apply_restart(1'b0);
        tests++;
        if ({lives, game_over, cmd_ready} !== {2'd3, 1'b0, 1'b1}) begin
            fails++; $display("FAIL restart_after_over: got lives=%0d over=%b ready=%b expected 3 0 1", lives, game_over, cmd_ready);
        end
    endtask

    task automatic test_level_clear();
        int r1, c1;
        for (int t = 1; t < 28 && !m_clear; t++) begin
            if (m_vis[t]) continue;
            r1 = 0;
            while (t >= r1 * (r1 + 1) / 2 + r1 + 1) r1++;
            c1 = t - r1 * (r1 + 1) / 2;
            while (m_row > 0) do_move(m_col > 0 ? 3'd4 : 3'd3, 1, 3 + int'($urandom_range(0, 3)), 1);
            for (int k = 0; k < c1 && !m_clear; k++) do_move(3'd1, 1, 3, 1 + int'($urandom_range(0, 2)));
            for (int k = 0; k < r1 - c1 && !m_clear; k++) do_move(3'd2, 2, 4, 1);
        end
        tests++;
        if ({level_clear, visited, score, cmd_ready} !== {1'b1, {28{1'b1}}, 16'd675, 1'b0}) begin
            fails++; $display("FAIL level_clear: got clear=%b vis=%h score=%0d ready=%b expected 1 fffffff 675 0",
                              level_clear, visited, score, cmd_ready);
        end
        do_move(3'd1, 2, 6, 2);
    endtask

    task automatic test_restart_flight();
        apply_restart(1'b1);
        do_move(3'd1, 2, 6, 2);
        cmd_valid = 1'b1; cmd_dir = 3'd2;
        step();
        cmd_valid = 1'b0;
        state_qb = BUSY;
        step();
        done_move = 1'b0;
        repeat (3) step();
        e_restart = 1'b1;
        step();
        e_restart = 1'b0;
        model_reset();
        tests++;
        if ({position_qb, e_next_qb, visited, score, lives, e_jump_qb, e_bad_jump, cmd_ready} !==
            {28'd1, 28'd1, 28'd1, 16'd0, 2'd3, 3'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL restart_flight: got pos=%h next=%h vis=%h score=%0d lives=%0d jump=%0d bad=%b ready=%b",
                              position_qb, e_next_qb, visited, score, lives, e_jump_qb, e_bad_jump, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_dir = 3'd1;
        step();
        cmd_valid = 1'b0;
        done_move = 1'b1;
        step();
        state_qb = IDLE;
        step();
        tests++;
        if ({e_jump_qb, e_next_qb, cmd_ready} !== {3'd0, 28'd1, 1'b1}) begin
            fails++; $display("FAIL busy_cmd_dropped: got jump=%0d next=%h ready=%b expected 0 1 1", e_jump_qb, e_next_qb, cmd_ready);
        end
        do_move(3'b111, 1, 3, 1);
        do_move(3'b000, 1, 3, 1);
        do_move(3'b101, 1, 3, 1);
    endtask

    task automatic test_random();
        logic [2:0] dir;
        int drop;
        apply_restart(1'b1);
        for (int n = 0; n < 200; n++) begin
            if (m_over || m_clear) apply_restart(1'b0);
            dir = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
            drop = int'($urandom_range(1, 4));
            do_move(dir, drop, drop + int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        reset = 1'b1; e_restart = 1'b0; cmd_valid = 1'b0; cmd_dir = 3'd0;
        done_move = 1'b1; state_qb = IDLE;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        test_reset();
        test_first_move();
        test_revisit();
        test_bad_jump();
        test_game_over();
        test_level_clear();
        test_restart_flight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
